// File: rtl/register_file_sb_pkg.sv
// Shared register-file definitions: default widths, the hard-wired zero
// register index and the address/data types used across the core.
package rf_pkg;

    localparam int RF_ADDRESS_WIDTH = 5;
    localparam int RF_DATA_WIDTH    = 32;

    // x0 reads as zero and never takes writes or issue marks
    localparam int REG_ZERO = 0;

    typedef logic [RF_ADDRESS_WIDTH-1:0] reg_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0]    reg_data_t;

endpackage

// File: rtl/register_file_sb_if.sv
// Register file bus: packed read ports, write ports, issue mark and debug tap.
// master = decode/issue + writeback side, slave = the register file.
interface register_file_sb_if
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 1
);
    logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr;
    logic [NUM_READ*DATA_WIDTH-1:0]     rd_data;
    logic [NUM_READ-1:0]                rd_busy;
    logic [NUM_WRITE-1:0]               wr_en;
    logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr;
    logic [NUM_WRITE*DATA_WIDTH-1:0]    wr_data;
    logic                               iss_en;
    logic [ADDRESS_WIDTH-1:0]           iss_addr;
    logic [DATA_WIDTH-1:0]              dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, dbg_data
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy scoreboard: set when a producer is issued, cleared when
// its result is written back. A same-cycle issue beats a writeback because
// the newer producer is still outstanding.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
    parameter int NUM_WRITE     = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               iss_en,
    input  logic [ADDRESS_WIDTH-1:0]           iss_addr,
    input  logic [NUM_WRITE-1:0]               wr_en,
    input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
    output logic [2**ADDRESS_WIDTH-1:0]        busy
);
    localparam int NREG = 2**ADDRESS_WIDTH;

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;

    // Next busy vector: writebacks clear first, then an issue sets, x0 stays idle
    always_comb begin
        busy_next = busy_reg;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w]) begin
                busy_next[wr_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    // Busy state; reset drops every outstanding producer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with optional write-to-read forwarding, synchronous
// clear, busy scoreboard and a fixed debug tap on one register.
module register_file_sb
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 1,
    parameter int BYPASS        = 1,
    parameter int DEBUG_REG     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    register_file_sb_if.slave bus
);
    localparam int NREG = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);
    localparam logic [ADDRESS_WIDTH-1:0] DBG_ADDR  = ADDRESS_WIDTH'(DEBUG_REG);

    logic [DATA_WIDTH-1:0]    mem_reg [NREG];
    logic [NREG-1:0]          busy_vec;
    logic [ADDRESS_WIDTH-1:0] wa [NUM_WRITE];
    logic [DATA_WIDTH-1:0]    wd [NUM_WRITE];

    // Unpack the write ports for readability below
    generate
        for (genvar gi = 0; gi < NUM_WRITE; gi++) begin : g_wr_unpack
            assign wa[gi] = bus.wr_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign wd[gi] = bus.wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Register array: clear on reset, otherwise commit writes in port order so
    // the highest-index port wins an address conflict; x0 is never written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem_reg[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (bus.wr_en[w] && wa[w] != ZERO_ADDR) begin
                    mem_reg[wa[w]] <= wd[w];
                end
            end
        end
    end

    rf_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_WRITE     (NUM_WRITE)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .busy     (busy_vec)
    );

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
            logic [ADDRESS_WIDTH-1:0] ra;
            logic [DATA_WIDTH-1:0]    data_sel;
            logic                     busy_sel;

            assign ra = bus.rd_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];

            // Read mux: stored value, overridden by a matching same-cycle write
            // (last matching port wins), and x0 forced to zero / not busy
            always_comb begin
                data_sel = mem_reg[ra];
                busy_sel = busy_vec[ra];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WRITE; w++) begin
                        if (bus.wr_en[w] && wa[w] == ra) begin
                            data_sel = wd[w];
                            busy_sel = 1'b0;
                        end
                    end
                end
                if (ra == ZERO_ADDR) begin
                    data_sel = '0;
                    busy_sel = 1'b0;
                end
            end

            assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_sel;
            assign bus.rd_busy[gi]                          = busy_sel;
        end
    endgenerate

    // Debug tap shows stored content only, never forwarded data
    assign bus.dbg_data = mem_reg[DBG_ADDR];

endmodule
